packet_train_monitor: RTL and testbench
=======================================

# packet_train_monitor

- Sink-side AXI4-Stream monitor that sits directly downstream of the packet generator.
- Accepts every beat and gathers per-train statistics:
  - packet count and byte count;
  - first and last packet timestamps;
  - min and max inter-packet gap;
  - framing errors (giant packets and bad strobes).
- All statistics go to read-only registers so software can check rate and integrity of a generated train.
- Signals when the expected number of packets has arrived.

## Interface
- C_S_AXIS_DATA_WIDTH, 256, stream data width (bytes = width/8)
- C_S_AXIS_TUSER_WIDTH, 128, tuser width (ignored, accepted only)
- TIMESTAMP_WIDTH, 64, width of stamp_counter
- MAX_BEATS, 64, beat count at which a packet without tlast is declared giant
- axi_aclk  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  stream data (ignored)
- s_axis_tstrb  in  C_S_AXIS_DATA_WIDTH/8  byte strobes
- s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  sideband (ignored)
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  registered; 0 in reset, 1 from first cycle after reset released
- s_axis_tlast  in  1  last beat of packet
- stamp_counter  in  TIMESTAMP_WIDTH  free-running time base
- clear  in  1  single-cycle pulse; zeroes statistics
- expected_packets  in  32  train length; 0 disables train_done
- pkt_count  out  32  good packets received, saturating
- byte_count  out  64  sum of asserted strobes over all accepted beats, wrapping
- first_ts, last_ts  out  64 each  stamp at first beat of first packet / at tlast of latest good packet
- min_gap  out  32  min gap between packets, stamp units
- max_gap  out  32  max gap between packets, stamp units
- giant_count  out  16  giant packets, saturating
- strb_err_count  out  16  packets with strobe error, saturating
- train_done  out  1  sticky
- busy  out  1  high while inside a packet

## Operation
- Beat accepted when tvalid & tready.
- States:
  - IDLE: no packet seen since reset/clear.
  - IN_PKT
  - GAP: between packets.
  - DISCARD: dropping the rest of a packet.
- IDLE/GAP + beat:
  - with tlast: one-beat packet; evaluate it and go to GAP;
  - without tlast: go to IN_PKT with beat_cnt=1.
- On the first beat of a packet:
  - latch start stamp;
  - from IDLE, also load first_ts;
  - from GAP, compute gap = start stamp − prev_end stamp (mod 2^64); saturate to 32 bits if upper bits are nonzero; update min_gap/max_gap.
- IN_PKT + beat: beat_cnt++.
- Packet end on tlast:
  - if no strobe error: pkt_count++, last_ts and prev_end ← stamp;
  - else strb_err_count++, and prev_end ← stamp only;
  - go to GAP.
- Giant: if beat_cnt reaches MAX_BEATS without tlast, giant_count++ and go to DISCARD. DISCARD returns to GAP on tlast and updates prev_end; pkt_count is unchanged.
- Strobe error (sticky per packet), any of:
  - tstrb = 0;
  - tstrb not of the form 2^k−1;
  - tstrb not all ones on a non-last beat.
- byte_count adds popcount(tstrb) for every accepted beat, in all states.
- train_done sets when pkt_count == expected_packets ≠ 0 after an update. It stays set until clear or reset. Packets keep being counted after it sets.
- Reset values:
  - all counters, first_ts, last_ts, max_gap: 0;
  - min_gap: 32'hFFFFFFFF;
  - train_done, busy: 0;
  - state: IDLE.
- clear:
  - resets the same registers as reset;
  - the beat in the same cycle is ignored;
  - if clear arrives mid-packet, or with a non-tlast beat, go to DISCARD; otherwise go to IDLE;
  - tready stays 1.
- busy = state is IN_PKT or DISCARD.

## Timing
- All outputs registered.
- Statistics reflect an accepted beat on the next rising edge (latency 1).
- Timestamps are sampled in the acceptance cycle.
- No backpressure after reset: tready never drops.
- Reset mid-packet: state goes to IDLE; the next beat is treated as a fresh packet start.
- Counter saturation: pkt_count at 2^32−1; giant_count and strb_err_count at 16'hFFFF.

## Structure
- Package pkt_mon_pkg:
  - state enum (IDLE, IN_PKT, GAP, DISCARD);
  - GAP_SAT constant (32'hFFFFFFFF);
  - function strb_contiguous.
- Sub-module strb_check: combinational popcount of tstrb (width clog2(bytes)+1) plus contiguity/zero flags.

## Test plan
- 3 packets of 2 beats, last tstrb 32'h0000FFFF, stamps 100/110/130 at starts, ends at 101/111/131 -> pkt_count 3, byte_count 144, first_ts 100, last_ts 131, min_gap 9, max_gap 19.
- expected_packets 2, send 3 one-beat full packets -> train_done high one cycle after 2nd tlast, stays high, pkt_count 3.
- 70-beat packet, MAX_BEATS 64 -> giant_count 1 at beat 64, busy until tlast, pkt_count 0, byte_count 2240.
- One-beat packet with tstrb 32'h0000F0F0 -> strb_err_count 1, pkt_count 0, byte_count 8.
- clear during beat 2 of a 4-beat packet, then a 1-beat packet -> all statistics zero after clear; afterwards pkt_count 1, first_ts = stamp of the new packet, min_gap FFFFFFFF.
- Reset asserted mid-train -> tready 0 during reset and 1 on the next cycle; all outputs at reset values.

Source files
------------

// File: rtl/pkt_mon_pkg.sv
// Shared types and helpers for the packet train monitor.
package pkt_mon_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IN_PKT  = 2'd1,
      GAP     = 2'd2,
      DISCARD = 2'd3
   } state_t;

   localparam logic [31:0] GAP_SAT  = 32'hFFFF_FFFF;
   localparam int          STRB_MAX = 128;

   // True when the strobe is of the form 2^k-1 (low bytes only, no holes); zero also qualifies.
   function automatic logic strb_contiguous(input logic [STRB_MAX-1:0] s);
      return ((s & (s + STRB_MAX'(1))) == '0);
   endfunction

endpackage

// File: rtl/strb_check.sv
// Combinational strobe qualifier: byte popcount plus zero / contiguous / all-ones flags.
// Zero latency; no flow control.
module strb_check
   import pkt_mon_pkg::*;
#(
   parameter  int BYTES = 32,
   localparam int CW    = $clog2(BYTES) + 1
) (
   input  logic [BYTES-1:0] strb_i,
   output logic [CW-1:0]    popcnt_o,
   output logic             zero_o,
   output logic             contig_o,
   output logic             all_ones_o
);

   always_comb begin
      popcnt_o = '0;
      for (int i = 0; i < BYTES; i++) begin
         popcnt_o = popcnt_o + CW'(strb_i[i]);
      end
   end

   assign zero_o     = ~|strb_i;
   assign all_ones_o = &strb_i;
   assign contig_o   = strb_contiguous(STRB_MAX'(strb_i));

endmodule

// File: rtl/packet_train_monitor.sv
// AXI4-Stream sink gathering per-train packet statistics; stats update 1 cycle after each beat.
// tready is a constant 1 once out of reset, so the monitor never backpressures.
module packet_train_monitor
   import pkt_mon_pkg::*;
#(
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int TIMESTAMP_WIDTH      = 64,
   parameter int MAX_BEATS            = 64
) (
   input  logic                              axi_aclk,
   input  logic                              reset,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   input  logic                              s_axis_tlast,
   input  logic [TIMESTAMP_WIDTH-1:0]        stamp_counter,
   input  logic                              clear,
   input  logic [31:0]                       expected_packets,
   output logic [31:0]                       pkt_count,
   output logic [63:0]                       byte_count,
   output logic [TIMESTAMP_WIDTH-1:0]        first_ts,
   output logic [TIMESTAMP_WIDTH-1:0]        last_ts,
   output logic [31:0]                       min_gap,
   output logic [31:0]                       max_gap,
   output logic [15:0]                       giant_count,
   output logic [15:0]                       strb_err_count,
   output logic                              train_done,
   output logic                              busy
);

   localparam int BYTES = C_S_AXIS_DATA_WIDTH / 8;
   localparam int CW    = $clog2(BYTES) + 1;
   localparam int BCW   = $clog2(MAX_BEATS) + 1;
   localparam int TSW   = TIMESTAMP_WIDTH;

   state_t               state_q, state_d;
   logic                 tready_q, busy_q;
   logic [31:0]          pkt_q, pkt_d, min_gap_q, min_gap_d, max_gap_q, max_gap_d;
   logic [63:0]          byte_q, byte_d;
   logic [TSW-1:0]       first_ts_q, first_ts_d, last_ts_q, last_ts_d, prev_end_q, prev_end_d;
   logic [15:0]          giant_q, giant_d, serr_q, serr_d;
   logic                 done_q, done_d, err_q, err_d, clr_disc_q, clr_disc_d;
   logic [BCW-1:0]       beat_cnt_q, beat_cnt_d, cnt_inc;

   logic [CW-1:0]        popcnt;
   logic                 strb_zero, strb_contig, strb_all_ones;
   logic                 beat, beat_err, end_pkt, end_err, in_pkt;
   logic [TSW-1:0]       gap_raw;
   logic [31:0]          gap;
   logic                 unused_ok;

   strb_check #(.BYTES(BYTES)) u_strb_check (
      .strb_i     (s_axis_tstrb),
      .popcnt_o   (popcnt),
      .zero_o     (strb_zero),
      .contig_o   (strb_contig),
      .all_ones_o (strb_all_ones)
   );

   assign unused_ok = ^{s_axis_tdata, s_axis_tuser};
   assign beat      = s_axis_tvalid & tready_q;
   assign beat_err  = strb_zero | ~strb_contig | (~s_axis_tlast & ~strb_all_ones);
   assign gap_raw   = stamp_counter - prev_end_q;
   assign gap       = (|gap_raw[TSW-1:32]) ? GAP_SAT : gap_raw[31:0];
   assign cnt_inc   = beat_cnt_q + BCW'(1);
   assign in_pkt    = (state_q == IN_PKT) || (state_q == DISCARD);

   always_comb begin
      state_d    = state_q;
      pkt_d      = pkt_q;
      byte_d     = byte_q;
      first_ts_d = first_ts_q;
      last_ts_d  = last_ts_q;
      prev_end_d = prev_end_q;
      min_gap_d  = min_gap_q;
      max_gap_d  = max_gap_q;
      giant_d    = giant_q;
      serr_d     = serr_q;
      done_d     = done_q;
      err_d      = err_q;
      beat_cnt_d = beat_cnt_q;
      clr_disc_d = clr_disc_q;
      end_pkt    = 1'b0;
      end_err    = 1'b0;
      if (clear) begin
         pkt_d      = '0;
         byte_d     = '0;
         first_ts_d = '0;
         last_ts_d  = '0;
         prev_end_d = '0;
         min_gap_d  = GAP_SAT;
         max_gap_d  = '0;
         giant_d    = '0;
         serr_d     = '0;
         done_d     = 1'b0;
         err_d      = 1'b0;
         beat_cnt_d = '0;
         // Leftover beats of an interrupted packet are dropped, then the train restarts from IDLE.
         if ((in_pkt && !(beat && s_axis_tlast)) || (beat && !s_axis_tlast)) begin
            state_d    = DISCARD;
            clr_disc_d = 1'b1;
         end else begin
            state_d    = IDLE;
            clr_disc_d = 1'b0;
         end
      end else if (beat) begin
         byte_d = byte_q + 64'(popcnt);
         unique case (state_q)
            IDLE, GAP: begin
               if (state_q == IDLE) begin
                  first_ts_d = stamp_counter;
               end else begin
                  if (gap < min_gap_q) min_gap_d = gap;
                  if (gap > max_gap_q) max_gap_d = gap;
               end
               if (s_axis_tlast) begin
                  end_pkt = 1'b1;
                  end_err = beat_err;
               end else begin
                  state_d    = IN_PKT;
                  beat_cnt_d = BCW'(1);
                  err_d      = beat_err;
               end
            end
            IN_PKT: begin
               if (s_axis_tlast) begin
                  end_pkt = 1'b1;
                  end_err = err_q | beat_err;
               end else if (cnt_inc == BCW'(MAX_BEATS)) begin
                  if (giant_q != 16'hFFFF) giant_d = giant_q + 16'd1;
                  state_d = DISCARD;
               end else begin
                  beat_cnt_d = cnt_inc;
                  err_d      = err_q | beat_err;
               end
            end
            DISCARD: begin
               if (s_axis_tlast) begin
                  prev_end_d = stamp_counter;
                  state_d    = clr_disc_q ? IDLE : GAP;
                  clr_disc_d = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
         if (end_pkt) begin
            state_d    = GAP;
            prev_end_d = stamp_counter;
            if (!end_err) begin
               if (pkt_q != 32'hFFFF_FFFF) pkt_d = pkt_q + 32'd1;
               last_ts_d = stamp_counter;
               if ((pkt_d == expected_packets) && (expected_packets != 32'd0)) done_d = 1'b1;
            end else if (serr_q != 16'hFFFF) begin
               serr_d = serr_q + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge axi_aclk) begin
      if (reset) begin
         state_q    <= IDLE;
         tready_q   <= 1'b0;
         busy_q     <= 1'b0;
         pkt_q      <= '0;
         byte_q     <= '0;
         first_ts_q <= '0;
         last_ts_q  <= '0;
         prev_end_q <= '0;
         min_gap_q  <= GAP_SAT;
         max_gap_q  <= '0;
         giant_q    <= '0;
         serr_q     <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         beat_cnt_q <= '0;
         clr_disc_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tready_q   <= 1'b1;
         busy_q     <= (state_d == IN_PKT) || (state_d == DISCARD);
         pkt_q      <= pkt_d;
         byte_q     <= byte_d;
         first_ts_q <= first_ts_d;
         last_ts_q  <= last_ts_d;
         prev_end_q <= prev_end_d;
         min_gap_q  <= min_gap_d;
         max_gap_q  <= max_gap_d;
         giant_q    <= giant_d;
         serr_q     <= serr_d;
         done_q     <= done_d;
         err_q      <= err_d;
         beat_cnt_q <= beat_cnt_d;
         clr_disc_q <= clr_disc_d;
      end
   end

   assign s_axis_tready  = tready_q;
   assign busy           = busy_q;
   assign pkt_count      = pkt_q;
   assign byte_count     = byte_q;
   assign first_ts       = first_ts_q;
   assign last_ts        = last_ts_q;
   assign min_gap        = min_gap_q;
   assign max_gap        = max_gap_q;
   assign giant_count    = giant_q;
   assign strb_err_count = serr_q;
   assign train_done     = done_q;

endmodule

// File: tb/tb_packet_train_monitor.sv
// Self-checking bench: table-driven statistics vectors plus hand-written giant/clear/reset/train_done sequences.
module tb_packet_train_monitor;

   localparam logic [31:0] M    = 32'hFFFF_FFFF;
   localparam logic [31:0] FULL = 32'hFFFF_FFFF;
   localparam logic [31:0] HALF = 32'h0000_FFFF;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [255:0]  s_axis_tdata = '0;
   logic [31:0]   s_axis_tstrb = '0;
   logic [127:0]  s_axis_tuser = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic          s_axis_tlast = 1'b0;
   logic [63:0]   stamp_counter = '0;
   logic          clear = 1'b0;
   logic [31:0]   expected_packets = '0;
   logic [31:0]   pkt_count, min_gap, max_gap;
   logic [63:0]   byte_count, first_ts, last_ts;
   logic [15:0]   giant_count, strb_err_count;
   logic          train_done, busy;

   int n_chk  = 0;
   int n_fail = 0;

   packet_train_monitor dut (
      .axi_aclk         (clk),
      .reset            (reset),
      .s_axis_tdata     (s_axis_tdata),
      .s_axis_tstrb     (s_axis_tstrb),
      .s_axis_tuser     (s_axis_tuser),
      .s_axis_tvalid    (s_axis_tvalid),
      .s_axis_tready    (s_axis_tready),
      .s_axis_tlast     (s_axis_tlast),
      .stamp_counter    (stamp_counter),
      .clear            (clear),
      .expected_packets (expected_packets),
      .pkt_count        (pkt_count),
      .byte_count       (byte_count),
      .first_ts         (first_ts),
      .last_ts          (last_ts),
      .min_gap          (min_gap),
      .max_gap          (max_gap),
      .giant_count      (giant_count),
      .strb_err_count   (strb_err_count),
      .train_done       (train_done),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        vld;
      logic        last;
      logic [31:0] strb;
      logic [63:0] stamp;
      logic [31:0] e_pkt;
      logic [63:0] e_bytes;
      logic [63:0] e_first;
      logic [63:0] e_last;
      logic [31:0] e_min;
      logic [31:0] e_max;
      logic [15:0] e_serr;
      logic        e_busy;
   } vec_t;

   vec_t vecs[13];
   vec_t sb[$];

   function automatic vec_t mkv(input logic vld, input logic last, input logic [31:0] strb,
                                input logic [63:0] stamp, input logic [31:0] e_pkt,
                                input logic [63:0] e_bytes, input logic [63:0] e_first,
                                input logic [63:0] e_last, input logic [31:0] e_min,
                                input logic [31:0] e_max, input logic [15:0] e_serr,
                                input logic e_busy);
      vec_t v;
      v.vld = vld;     v.last = last;       v.strb = strb;       v.stamp = stamp;
      v.e_pkt = e_pkt; v.e_bytes = e_bytes; v.e_first = e_first; v.e_last = e_last;
      v.e_min = e_min; v.e_max = e_max;     v.e_serr = e_serr;   v.e_busy = e_busy;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
      end
   endtask

   task automatic beat(input logic last, input logic [31:0] strb, input logic [63:0] stamp,
                       input logic clr);
      @(negedge clk);
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = last;
      s_axis_tstrb  = strb;
      stamp_counter = stamp;
      clear         = clr;
      s_axis_tdata  = {8{$urandom()}};
      s_axis_tuser  = {4{$urandom()}};
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      clear         = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset         = 1'b1;
      s_axis_tvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " pkt_count"},      64'(pkt_count), 64'd0);
      chk({tag, " byte_count"},     byte_count, 64'd0);
      chk({tag, " first_ts"},       first_ts, 64'd0);
      chk({tag, " last_ts"},        last_ts, 64'd0);
      chk({tag, " min_gap"},        64'(min_gap), 64'(M));
      chk({tag, " max_gap"},        64'(max_gap), 64'd0);
      chk({tag, " giant_count"},    64'(giant_count), 64'd0);
      chk({tag, " strb_err_count"}, 64'(strb_err_count), 64'd0);
      chk({tag, " train_done"},     64'(train_done), 64'd0);
      chk({tag, " busy"},           64'(busy), 64'd0);
   endtask

   initial begin
      vec_t e;
      //            vld  last strb            stamp             pkt bytes first last             min  max   serr busy
      vecs[0]  = mkv(1'b1, 1'b0, FULL,          64'd100,          0, 32,  100, 0,               M,   0,    0, 1'b1);
      vecs[1]  = mkv(1'b1, 1'b1, HALF,          64'd101,          1, 48,  100, 101,             M,   0,    0, 1'b0);
      vecs[2]  = mkv(1'b0, 1'b0, FULL,          64'd105,          1, 48,  100, 101,             M,   0,    0, 1'b0);
      vecs[3]  = mkv(1'b1, 1'b0, FULL,          64'd110,          1, 80,  100, 101,             9,   9,    0, 1'b1);
      vecs[4]  = mkv(1'b1, 1'b1, HALF,          64'd111,          2, 96,  100, 111,             9,   9,    0, 1'b0);
      vecs[5]  = mkv(1'b1, 1'b0, FULL,          64'd130,          2, 128, 100, 111,             9,   19,   0, 1'b1);
      vecs[6]  = mkv(1'b1, 1'b1, HALF,          64'd131,          3, 144, 100, 131,             9,   19,   0, 1'b0);
      vecs[7]  = mkv(1'b1, 1'b1, 32'h0000_F0F0, 64'd140,          3, 152, 100, 131,             9,   19,   1, 1'b0);
      vecs[8]  = mkv(1'b1, 1'b1, 32'h0,         64'd200,          3, 152, 100, 131,             9,   60,   2, 1'b0);
      vecs[9]  = mkv(1'b1, 1'b0, HALF,          64'd300,          3, 168, 100, 131,             9,   100,  2, 1'b1);
      vecs[10] = mkv(1'b1, 1'b1, FULL,          64'd301,          3, 200, 100, 131,             9,   100,  3, 1'b0);
      vecs[11] = mkv(1'b1, 1'b1, FULL,          64'h2_0000_0000,  4, 232, 100, 64'h2_0000_0000, 9,   M,    3, 1'b0);
      vecs[12] = mkv(1'b1, 1'b1, FULL,          64'h2_0000_0000,  5, 264, 100, 64'h2_0000_0000, 0,   M,    3, 1'b0);

      // Reset state and tready release
      repeat (2) @(posedge clk);
      #1;
      chk("tready in reset", 64'(s_axis_tready), 64'd0);
      chk_reset_vals("por");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("tready after reset", 64'(s_axis_tready), 64'd1);

      // Table: gaps, byte counts, strobe errors, gap saturation
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         s_axis_tvalid = vecs[i].vld;
         s_axis_tlast  = vecs[i].last;
         s_axis_tstrb  = vecs[i].strb;
         stamp_counter = vecs[i].stamp;
         sb.push_back(vecs[i]);
         @(posedge clk);
         #1;
         s_axis_tvalid = 1'b0;
         e = sb.pop_front();
         chk($sformatf("v%0d pkt_count", i),   64'(pkt_count), 64'(e.e_pkt));
         chk($sformatf("v%0d byte_count", i),  byte_count, e.e_bytes);
         chk($sformatf("v%0d first_ts", i),    first_ts, e.e_first);
         chk($sformatf("v%0d last_ts", i),     last_ts, e.e_last);
         chk($sformatf("v%0d min_gap", i),     64'(min_gap), 64'(e.e_min));
         chk($sformatf("v%0d max_gap", i),     64'(max_gap), 64'(e.e_max));
         chk($sformatf("v%0d strb_err", i),    64'(strb_err_count), 64'(e.e_serr));
         chk($sformatf("v%0d busy", i),        64'(busy), 64'(e.e_busy));
      end

      // Reset in the middle of a packet; next beat starts a fresh train
      beat(1'b0, FULL, 64'd500, 1'b0);
      chk("pre-reset busy", 64'(busy), 64'd1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("tready mid reset", 64'(s_axis_tready), 64'd0);
      chk_reset_vals("midrst");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("tready post midrst", 64'(s_axis_tready), 64'd1);
      beat(1'b1, FULL, 64'd600, 1'b0);
      chk("midrst pkt_count", 64'(pkt_count), 64'd1);
      chk("midrst first_ts", first_ts, 64'd600);
      chk("midrst min_gap", 64'(min_gap), 64'(M));

      // Giant packet: 70 beats with MAX_BEATS 64
      do_reset();
      for (int b = 1; b <= 70; b++) begin
         beat(b == 70, FULL, 64'(1000 + b), 1'b0);
         if (b == 63) begin
            chk("giant@63 count", 64'(giant_count), 64'd0);
            chk("giant@63 busy", 64'(busy), 64'd1);
         end
         if (b == 64) begin
            chk("giant@64 count", 64'(giant_count), 64'd1);
            chk("giant@64 busy", 64'(busy), 64'd1);
         end
         if (b == 69) chk("giant@69 busy", 64'(busy), 64'd1);
      end
      chk("giant end busy", 64'(busy), 64'd0);
      chk("giant end count", 64'(giant_count), 64'd1);
      chk("giant pkt_count", 64'(pkt_count), 64'd0);
      chk("giant byte_count", byte_count, 64'd2240);

      // Single-beat packet with holes in the strobe
      do_reset();
      beat(1'b1, 32'h0000_F0F0, 64'd10, 1'b0);
      chk("holes strb_err", 64'(strb_err_count), 64'd1);
      chk("holes pkt_count", 64'(pkt_count), 64'd0);
      chk("holes byte_count", byte_count, 64'd8);

      // train_done with expected_packets = 2
      do_reset();
      expected_packets = 32'd2;
      beat(1'b1, FULL, 64'd10, 1'b0);
      chk("done after 1", 64'(train_done), 64'd0);
      beat(1'b1, FULL, 64'd20, 1'b0);
      chk("done after 2", 64'(train_done), 64'd1);
      @(posedge clk);
      #1;
      chk("done sticky idle", 64'(train_done), 64'd1);
      beat(1'b1, FULL, 64'd30, 1'b0);
      chk("done after 3", 64'(train_done), 64'd1);
      chk("done pkt_count", 64'(pkt_count), 64'd3);
      expected_packets = 32'd0;

      // clear on beat 2 of a 4-beat packet, then a single-beat packet
      do_reset();
      beat(1'b1, FULL, 64'd5, 1'b0);
      beat(1'b0, FULL, 64'd10, 1'b0);
      chk("preclr min_gap", 64'(min_gap), 64'd5);
      beat(1'b0, FULL, 64'd11, 1'b1);
      chk("clr pkt_count", 64'(pkt_count), 64'd0);
      chk("clr byte_count", byte_count, 64'd0);
      chk("clr first_ts", first_ts, 64'd0);
      chk("clr last_ts", last_ts, 64'd0);
      chk("clr min_gap", 64'(min_gap), 64'(M));
      chk("clr max_gap", 64'(max_gap), 64'd0);
      chk("clr busy", 64'(busy), 64'd1);
      chk("clr tready", 64'(s_axis_tready), 64'd1);
      beat(1'b0, FULL, 64'd12, 1'b0);
      beat(1'b1, FULL, 64'd13, 1'b0);
      chk("discard pkt_count", 64'(pkt_count), 64'd0);
      chk("discard busy", 64'(busy), 64'd0);
      beat(1'b1, FULL, 64'd20, 1'b0);
      chk("postclr pkt_count", 64'(pkt_count), 64'd1);
      chk("postclr first_ts", first_ts, 64'd20);
      chk("postclr last_ts", last_ts, 64'd20);
      chk("postclr min_gap", 64'(min_gap), 64'(M));
      chk("postclr byte_count", byte_count, 64'd96);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
